// File: rtl/vrp_dispatch.sv
// Routes one valid/ready stream to WIDTH consumers by destination index.
// Each destination owns a small FIFO, so one stalled consumer only blocks its own beats.
module vrp_dispatch #(
  parameter int WIDTH     = 4,
  parameter int PLD_WIDTH = 32,
  parameter int DEPTH     = 2,
  parameter int DST_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  vld_s,
  output logic                                  rdy_s,
  input  logic [PLD_WIDTH-1:0]                  pld_s,
  input  logic [DST_WIDTH-1:0]                  dst_s,
  output logic [WIDTH-1:0]                      v_vld_m,
  input  logic [WIDTH-1:0]                      v_rdy_m,
  output logic [PLD_WIDTH-1:0]                  v_pld_m [WIDTH],
  output logic [WIDTH-1:0][$clog2(DEPTH):0]     v_cnt_m,
  output logic                                  err_dst
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NPAD  = 1 << DST_WIDTH;

  logic [PLD_WIDTH-1:0] mem    [WIDTH][DEPTH];
  logic [PTR_W-1:0]     wr_ptr [WIDTH];
  logic [PTR_W-1:0]     rd_ptr [WIDTH];
  logic [CNT_W-1:0]     cnt    [WIDTH];

  logic [NPAD-1:0]  full_pad;
  logic             dst_ok;
  logic [WIDTH-1:0] push;
  logic [WIDTH-1:0] pop;

  // Ready is built from registered occupancy only; a same-cycle pop never frees a slot.
  always_comb begin
    full_pad = '0;
    for (int i = 0; i < WIDTH; i++) begin
      full_pad[i] = (cnt[i] == CNT_W'(DEPTH));
    end
    dst_ok = (32'(dst_s) < WIDTH);
    rdy_s  = dst_ok ? ~full_pad[dst_s] : 1'b1;
  end

  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      push[i] = vld_s & rdy_s & dst_ok & (dst_s == DST_WIDTH'(i));
      pop[i]  = (cnt[i] != '0) & v_rdy_m[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          mem[i][j] <= '0;
        end
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      err_dst <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= pld_s;
          wr_ptr[i]         <= wr_ptr[i] + PTR_W'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        end
        if (push[i] && !pop[i]) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (pop[i] && !push[i]) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
      // Out-of-range beats are swallowed; the flag records that it happened.
      if (vld_s && !dst_ok) begin
        err_dst <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      v_vld_m[i] = (cnt[i] != '0);
      v_pld_m[i] = mem[i][rd_ptr[i]];
      v_cnt_m[i] = cnt[i];
    end
  end

endmodule

// File: tb/tb_vrp_dispatch.sv
// Self-checking bench for vrp_dispatch: a 4-way instance checked against per-destination
// queues, plus a 3-way instance for the out-of-range destination behaviour.
module tb_vrp_dispatch;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        vld;
  logic        rdy_s;
  logic [31:0] pld;
  logic [1:0]  dst;
  logic [3:0]  vld_m;
  logic [3:0]  rdy_m;
  logic [31:0] pld_m [4];
  logic [3:0][1:0] cnt_m;
  logic        err;

  logic        vld3;
  logic        rdy_s3;
  logic [31:0] pld3;
  logic [1:0]  dst3;
  logic [2:0]  vld_m3;
  logic [2:0]  rdy_m3;
  logic [31:0] pld_m3 [3];
  logic [2:0][1:0] cnt_m3;
  logic        err3;

  int checks = 0;
  int errors = 0;

  logic [31:0] mq [4][$];

  vrp_dispatch #(.WIDTH(4), .PLD_WIDTH(32), .DEPTH(DEPTH)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .vld_s(vld), .rdy_s(rdy_s), .pld_s(pld), .dst_s(dst),
    .v_vld_m(vld_m), .v_rdy_m(rdy_m), .v_pld_m(pld_m), .v_cnt_m(cnt_m), .err_dst(err)
  );

  vrp_dispatch #(.WIDTH(3), .PLD_WIDTH(32), .DEPTH(DEPTH)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .vld_s(vld3), .rdy_s(rdy_s3), .pld_s(pld3), .dst_s(dst3),
    .v_vld_m(vld_m3), .v_rdy_m(rdy_m3), .v_pld_m(pld_m3), .v_cnt_m(cnt_m3), .err_dst(err3)
  );

  // Advance one clock; the model accepts/pops using the state seen before the edge.
  task automatic tick();
    bit          acc;
    logic [3:0]  pops;
    logic [1:0]  d;
    logic [31:0] p;
    acc = vld && (mq[dst].size() < DEPTH);
    d = dst;
    p = pld;
    for (int i = 0; i < 4; i++) pops[i] = (mq[i].size() != 0) && rdy_m[i];
    @(posedge clk);
    for (int i = 0; i < 4; i++) if (pops[i]) void'(mq[i].pop_front());
    if (acc) mq[d].push_back(p);
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    settle();
    checks++;
    if (vld_m !== 4'b0 || cnt_m !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs vld=%b cnt=%h err=%b want vld=0 cnt=0 err=0", vld_m, cnt_m, err);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pld_m[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset_pld lane %0d got %h want 0", i, pld_m[i]);
      end
    end
    checks++;
    if (vld_m3 !== 3'b0 || err3 !== 1'b0 || rdy_s !== 1'b1) begin
      errors++;
      $display("FAIL reset_w3 vld3=%b err3=%b rdy=%b want 0 0 1", vld_m3, err3, rdy_s);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_route();
    rdy_m = 4'hF;
    for (int k = 0; k < 4; k++) begin
      vld = 1'b1; dst = 2'(k); pld = 32'hA0 + 32'(k);
      settle();
      checks++;
      if (rdy_s !== 1'b1) begin
        errors++;
        $display("FAIL route_rdy beat %0d got %b want 1", k, rdy_s);
      end
      tick();
      settle();
      checks++;
      if (vld_m !== (4'b1 << k) || pld_m[k] !== 32'hA0 + 32'(k)) begin
        errors++;
        $display("FAIL route_out beat %0d vld=%b pld=%h want vld=%b pld=%h",
                 k, vld_m, pld_m[k], 4'b1 << k, 32'hA0 + 32'(k));
      end
    end
    vld = 1'b0;
    tick();
    settle();
    checks++;
    if (cnt_m !== '0 || vld_m !== 4'b0) begin
      errors++;
      $display("FAIL route_drain cnt=%h vld=%b want 0 0", cnt_m, vld_m);
    end
  endtask

  task automatic test_backpressure();
    rdy_m = 4'b1011;
    vld = 1'b1; dst = 2'd2;
    for (int k = 0; k < 2; k++) begin
      pld = 32'hB0 + 32'(k);
      settle();
      checks++;
      if (rdy_s !== 1'b1) begin
        errors++;
        $display("FAIL bp_accept beat %0d rdy=%b want 1", k, rdy_s);
      end
      tick();
    end
    pld = 32'hB2;
    settle();
    checks++;
    if (rdy_s !== 1'b0 || cnt_m[2] !== 2'd2) begin
      errors++;
      $display("FAIL bp_full rdy=%b cnt=%0d want rdy=0 cnt=2", rdy_s, cnt_m[2]);
    end
    tick();
    rdy_m = 4'hF;
    settle();
    checks++;
    if (rdy_s !== 1'b0 || pld_m[2] !== 32'hB0) begin
      errors++;
      $display("FAIL bp_pop_no_rdy rdy=%b head=%h want rdy=0 head=b0", rdy_s, pld_m[2]);
    end
    tick();
    settle();
    checks++;
    if (rdy_s !== 1'b1 || cnt_m[2] !== 2'd1 || pld_m[2] !== 32'hB1) begin
      errors++;
      $display("FAIL bp_after_pop rdy=%b cnt=%0d head=%h want 1 1 b1", rdy_s, cnt_m[2], pld_m[2]);
    end
    tick();
    vld = 1'b0;
    settle();
    checks++;
    if (cnt_m[2] !== 2'd1 || pld_m[2] !== 32'hB2) begin
      errors++;
      $display("FAIL bp_third cnt=%0d head=%h want 1 b2", cnt_m[2], pld_m[2]);
    end
    tick();
    settle();
    checks++;
    if (cnt_m[2] !== 2'd0) begin
      errors++;
      $display("FAIL bp_drain cnt=%0d want 0", cnt_m[2]);
    end
  endtask

  task automatic test_hol();
    rdy_m = 4'b1101;
    vld = 1'b1; dst = 2'd1;
    pld = 32'hC0; tick();
    pld = 32'hC1; tick();
    dst = 2'd3; pld = 32'hC3;
    settle();
    checks++;
    if (rdy_s !== 1'b1) begin
      errors++;
      $display("FAIL hol_rdy got %b want 1", rdy_s);
    end
    tick();
    vld = 1'b0;
    settle();
    checks++;
    if (vld_m[3] !== 1'b1 || pld_m[3] !== 32'hC3 || cnt_m[1] !== 2'd2 || pld_m[1] !== 32'hC0) begin
      errors++;
      $display("FAIL hol_iso vld3=%b pld3=%h cnt1=%0d head1=%h want 1 c3 2 c0",
               vld_m[3], pld_m[3], cnt_m[1], pld_m[1]);
    end
    rdy_m = 4'hF;
    tick();
    tick();
    settle();
    checks++;
    if (cnt_m !== '0) begin
      errors++;
      $display("FAIL hol_drain cnt=%h want 0", cnt_m);
    end
  endtask

  task automatic test_simul();
    rdy_m = 4'b1110;
    vld = 1'b1; dst = 2'd0; pld = 32'hD0;
    tick();
    rdy_m = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      pld = 32'hD0 + 32'(k);
      settle();
      checks++;
      if (cnt_m[0] !== 2'd1 || pld_m[0] !== 32'hD0 + 32'(k - 1) || rdy_s !== 1'b1) begin
        errors++;
        $display("FAIL simul step %0d cnt=%0d head=%h rdy=%b want 1 %h 1",
                 k, cnt_m[0], pld_m[0], rdy_s, 32'hD0 + 32'(k - 1));
      end
      tick();
    end
    vld = 1'b0;
    settle();
    checks++;
    if (cnt_m[0] !== 2'd1 || pld_m[0] !== 32'hD8) begin
      errors++;
      $display("FAIL simul_last cnt=%0d head=%h want 1 d8", cnt_m[0], pld_m[0]);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    rdy_m3 = 3'b111;
    vld3 = 1'b1; dst3 = 2'd3; pld3 = 32'h55;
    settle();
    checks++;
    if (rdy_s3 !== 1'b1 || err3 !== 1'b0) begin
      errors++;
      $display("FAIL oor_accept rdy=%b err=%b want 1 0", rdy_s3, err3);
    end
    tick();
    vld3 = 1'b0;
    settle();
    checks++;
    if (err3 !== 1'b1 || vld_m3 !== 3'b0 || cnt_m3 !== '0) begin
      errors++;
      $display("FAIL oor_err err=%b vld=%b cnt=%h want 1 0 0", err3, vld_m3, cnt_m3);
    end
    vld3 = 1'b1; dst3 = 2'd2; pld3 = 32'h66;
    tick();
    vld3 = 1'b0;
    tick();
    settle();
    checks++;
    if (err3 !== 1'b1) begin
      errors++;
      $display("FAIL oor_sticky err=%b want 1", err3);
    end
  endtask

  task automatic test_reset_mid();
    rdy_m = 4'b0000;
    vld = 1'b1;
    dst = 2'd0; pld = 32'hE0; tick();
    dst = 2'd1; pld = 32'hE1; tick();
    vld = 1'b0;
    settle();
    checks++;
    if (cnt_m[0] !== 2'd1 || cnt_m[1] !== 2'd1) begin
      errors++;
      $display("FAIL rmid_pre cnt0=%0d cnt1=%0d want 1 1", cnt_m[0], cnt_m[1]);
    end
    rst_n = 1'b0;
    settle();
    checks++;
    if (vld_m !== 4'b0 || cnt_m !== '0 || err3 !== 1'b0 || pld_m[0] !== 32'h0) begin
      errors++;
      $display("FAIL rmid_async vld=%b cnt=%h err3=%b pld0=%h want 0 0 0 0", vld_m, cnt_m, err3, pld_m[0]);
    end
    for (int i = 0; i < 4; i++) mq[i].delete();
    @(negedge clk);
    rst_n = 1'b1;
    rdy_m = 4'hF;
    vld = 1'b1; dst = 2'd1; pld = 32'hF1;
    tick();
    vld = 1'b0;
    settle();
    checks++;
    if (vld_m !== 4'b0010 || pld_m[1] !== 32'hF1) begin
      errors++;
      $display("FAIL rmid_after vld=%b pld1=%h want 0010 f1", vld_m, pld_m[1]);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      vld   = 1'($urandom_range(0, 3) != 0);
      dst   = 2'($urandom);
      pld   = $urandom;
      rdy_m = 4'($urandom);
      settle();
      checks++;
      if (rdy_s !== (mq[dst].size() < DEPTH)) begin
        errors++;
        $display("FAIL rand_rdy cyc %0d dst %0d got %b want %b", n, dst, rdy_s, mq[dst].size() < DEPTH);
      end
      tick();
      settle();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (vld_m[i] !== (mq[i].size() != 0) || cnt_m[i] !== 2'(mq[i].size()) ||
            (mq[i].size() != 0 && pld_m[i] !== mq[i][0])) begin
          errors++;
          $display("FAIL rand_lane cyc %0d lane %0d vld=%b cnt=%0d pld=%h want vld=%b cnt=%0d pld=%h",
                   n, i, vld_m[i], cnt_m[i], pld_m[i], mq[i].size() != 0, mq[i].size(),
                   (mq[i].size() != 0) ? mq[i][0] : 32'h0);
        end
      end
    end
    vld = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL rand_err got %b want 0", err);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    vld = 1'b0; pld = '0; dst = '0; rdy_m = '0;
    vld3 = 1'b0; pld3 = '0; dst3 = '0; rdy_m3 = '0;
    test_reset();
    test_basic_route();
    test_backpressure();
    test_hol();
    test_simul();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vrp_dispatch.md
Name: vrp_dispatch

Overview:
- Dispatches one valid/ready request stream to WIDTH valid/ready consumers, selected by a destination index carried with each beat.
- Performs the fan-out counterpart of the icache fixed-priority arbiter.
- Each destination has a private DEPTH-entry FIFO, so a stalled consumer blocks only beats addressed to it.
- Sits between the icache response/refill source and per-requestor return ports.

Parameters:
- WIDTH, 4, number of destinations (2..16).
- PLD_WIDTH, 32, payload width in bits.
- DEPTH, 2, entries per destination FIFO; power of two, at least 2.
- DST_WIDTH, $clog2(WIDTH) (minimum 1), width of the destination index.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- vld_s  input  1  inbound beat valid.
- rdy_s  output  1  inbound beat ready.
- pld_s  input  PLD_WIDTH  inbound payload.
- dst_s  input  DST_WIDTH  destination index of the inbound beat.
- v_vld_m  output  WIDTH  per-destination valid.
- v_rdy_m  input  WIDTH  per-destination ready.
- v_pld_m  output  PLD_WIDTH [WIDTH-1:0]  per-destination payload (unpacked array).
- v_cnt_m  output  ($clog2(DEPTH)+1) [WIDTH-1:0]  per-destination FIFO occupancy.
- err_dst  output  1  sticky flag: a beat was received with dst_s >= WIDTH.

Behaviour:
- Reset (async assert, sync release): all FIFOs empty, v_vld_m=0, v_cnt_m=0 for every destination, err_dst=0, v_pld_m=0 (storage cleared).
- Input handshake:
  - rdy_s = (dst_s >= WIDTH) ? 1 : ~full[dst_s], where full[i] = (cnt[i]==DEPTH).
  - rdy_s depends only on registered state and dst_s; it never depends on v_rdy_m (no combinational ready path).
  - A transfer occurs when vld_s & rdy_s. The accepted beat is pushed into FIFO[dst_s].
- Latency: a beat accepted in cycle N is presented on v_vld_m[dst] in cycle N+1 at the earliest. There is no same-cycle pass-through.
- Output handshake:
  - v_vld_m[i] = (cnt[i] != 0); v_pld_m[i] = head entry of FIFO[i].
  - A pop occurs when v_vld_m[i] & v_rdy_m[i].
  - v_vld_m/v_pld_m remain stable while valid and not ready.
- Per-FIFO pointers: wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH. cnt is $clog2(DEPTH)+1 bits.
- Push and pop in the same cycle on the same FIFO: cnt unchanged, both pointers advance.
- Full FIFO: a same-cycle pop does NOT make rdy_s high; the push waits one cycle.
- Empty FIFO: a push appears next cycle; a pop is impossible since valid is 0.
- Different FIFOs: independent; any combination of push and pops in one cycle is legal.
- Out-of-range dst_s (only possible when WIDTH is not a power of two): the beat is accepted (rdy_s=1) and discarded; err_dst sets next cycle and holds until reset.
- Ordering: order is preserved per destination. There is no ordering guarantee across destinations.
- Reset mid-operation: all buffered beats are lost. Outputs return to reset values immediately on rst_n low.
- Input rules: dst_s and pld_s are sampled only on a transfer. vld_s may drop without a handshake (the block tolerates it; upstream is expected to hold).

Test Plan:
- Basic route: WIDTH=4, all v_rdy_m=1. Send pld 0xA0..0xA3 with dst 0..3 on consecutive cycles. Required: each appears on v_vld_m[dst] exactly one cycle after acceptance, rdy_s stays 1, and all v_cnt_m return to 0.
- Backpressure/full: v_rdy_m[2]=0. Send 3 beats to dst 2. Required: the first two are accepted, cnt[2]=2, rdy_s=0 on the third. Then raise v_rdy_m[2]: 0x.. pops in order, and the third is accepted one cycle after cnt drops to 1.
- Head-of-line isolation: dst 1 full and stalled. Send a beat to dst 3. Required: rdy_s=1 and the beat appears on v_vld_m[3] next cycle, with dst 1 untouched.
- Simultaneous push/pop: cnt[0]=1 with v_rdy_m[0]=1 while pushing to dst 0 every cycle for 8 cycles. Required: cnt[0] stays 1 and the 8 payloads emerge in order, one per cycle.
- Out-of-range: WIDTH=3, send dst=3 pld 0x55. Required: accepted, no v_vld_m asserted, err_dst=1 next cycle and sticky.
- Async reset mid-traffic: assert rst_n=0 with FIFOs holding 2 beats. Required: v_vld_m=0, v_cnt_m=0, err_dst=0 immediately. After release, new traffic routes correctly with no stale beats.
